// File: rtl/fl_cutter_arbiter.sv
// Round-robin, frame-granular FrameLink arbiter in front of a shared fl_cutter.
// Optional per-input EOF counters are enabled with FL_CUTTER_ARBITER_STATS_EN.
module fl_cutter_arbiter_lane (
  input  logic src_rdy_n,
  input  logic sof_n,
  input  logic grant,
  input  logic tx_dst_rdy_n,
  output logic req,
  output logic dst_rdy_n
);
  // Only a frame start can win arbitration; mid-frame words wait for their grant.
  assign req       = ~src_rdy_n & ~sof_n;
  assign dst_rdy_n = grant ? tx_dst_rdy_n : 1'b1;
endmodule

module fl_cutter_arbiter #(
  parameter int INPUTS     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DREM_WIDTH = 3,
  parameter int CHAN_WIDTH = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [INPUTS*DATA_WIDTH-1:0] RX_DATA,
  input  logic [INPUTS*DREM_WIDTH-1:0] RX_REM,
  input  logic [INPUTS-1:0]            RX_SOF_N,
  input  logic [INPUTS-1:0]            RX_EOF_N,
  input  logic [INPUTS-1:0]            RX_SOP_N,
  input  logic [INPUTS-1:0]            RX_EOP_N,
  input  logic [INPUTS-1:0]            RX_SRC_RDY_N,
  output logic [INPUTS-1:0]            RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]        TX_DATA,
  output logic [DREM_WIDTH-1:0]        TX_REM,
  output logic                         TX_SOF_N,
  output logic                         TX_EOF_N,
  output logic                         TX_SOP_N,
  output logic                         TX_EOP_N,
  output logic                         TX_SRC_RDY_N,
  input  logic                         TX_DST_RDY_N,
  output logic [CHAN_WIDTH-1:0]        TX_CHANNEL
`ifdef FL_CUTTER_ARBITER_STATS_EN
  ,
  input  logic                         CNT_CLEAR,
  output logic [INPUTS*32-1:0]         FRAME_CNT
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                            state, state_nxt;
  logic [CHAN_WIDTH-1:0]             ptr, ptr_nxt, sel, sel_nxt, hit;
  logic                              found, xfer, last;
  logic [INPUTS-1:0]                 req, grant;
  logic [INPUTS-1:0][DATA_WIDTH-1:0] rx_data_a;
  logic [INPUTS-1:0][DREM_WIDTH-1:0] rx_rem_a;

  assign rx_data_a = RX_DATA;
  assign rx_rem_a  = RX_REM;

  for (genvar i = 0; i < INPUTS; i++) begin : g_lane
    assign grant[i] = (state == LOCKED) && (sel == CHAN_WIDTH'(i));
    fl_cutter_arbiter_lane u_lane (
      .src_rdy_n    (RX_SRC_RDY_N[i]),
      .sof_n        (RX_SOF_N[i]),
      .grant        (grant[i]),
      .tx_dst_rdy_n (TX_DST_RDY_N),
      .req          (req[i]),
      .dst_rdy_n    (RX_DST_RDY_N[i])
    );
  end

  // Rotating priority search starting at ptr; the sum never exceeds 2*INPUTS-2.
  always_comb begin
    logic [CHAN_WIDTH:0] sum;
    found = 1'b0;
    hit   = ptr;
    sum   = '0;
    for (int k = 0; k < INPUTS; k++) begin
      sum = {1'b0, ptr} + (CHAN_WIDTH+1)'(k);
      if (sum >= (CHAN_WIDTH+1)'(INPUTS)) sum = sum - (CHAN_WIDTH+1)'(INPUTS);
      if (!found && req[sum[CHAN_WIDTH-1:0]]) begin
        found = 1'b1;
        hit   = sum[CHAN_WIDTH-1:0];
      end
    end
  end

  assign xfer = (state == LOCKED) & ~RX_SRC_RDY_N[sel] & ~TX_DST_RDY_N;
  assign last = ~RX_EOF_N[sel];

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (found) begin
        sel_nxt   = hit;
        state_nxt = LOCKED;
      end
      LOCKED: if (xfer && last) begin
        state_nxt = IDLE;
        ptr_nxt   = (sel == CHAN_WIDTH'(INPUTS-1)) ? '0 : sel + CHAN_WIDTH'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
    end
  end

  // Data path is a pure mux while locked: no added latency toward the cutter.
  always_comb begin
    TX_DATA      = '0;
    TX_REM       = '0;
    TX_SOF_N     = 1'b1;
    TX_EOF_N     = 1'b1;
    TX_SOP_N     = 1'b1;
    TX_EOP_N     = 1'b1;
    TX_SRC_RDY_N = 1'b1;
    TX_CHANNEL   = '0;
    if (state == LOCKED) begin
      TX_DATA      = rx_data_a[sel];
      TX_REM       = rx_rem_a[sel];
      TX_SOF_N     = RX_SOF_N[sel];
      TX_EOF_N     = RX_EOF_N[sel];
      TX_SOP_N     = RX_SOP_N[sel];
      TX_EOP_N     = RX_EOP_N[sel];
      TX_SRC_RDY_N = RX_SRC_RDY_N[sel];
      TX_CHANNEL   = sel;
    end
  end

`ifdef FL_CUTTER_ARBITER_STATS_EN
  logic [INPUTS-1:0][31:0] cnt;

  // Clear wins over a same-cycle EOF so software sees a clean zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)               cnt      <= '0;
    else if (CNT_CLEAR)      cnt      <= '0;
    else if (xfer && last)   cnt[sel] <= cnt[sel] + 32'd1;
  end

  assign FRAME_CNT = cnt;
`endif

endmodule

// File: tb/tb_fl_cutter_arbiter.sv
// Directed bench for fl_cutter_arbiter: reset, fairness, isolation, backpressure,
// mid-frame reset and (with FL_CUTTER_ARBITER_STATS_EN) frame counters.
module tb_fl_cutter_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int RW = 3;
  localparam int CW = 2;
  localparam logic [6:0] IDLE_CTL = 7'b000_1111;
  localparam logic [6:0] MID_CTL  = 7'b111_1111;
  localparam logic [6:0] ONE_CTL  = 7'b000_0000;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [N*DW-1:0]   rx_data;
  logic [N*RW-1:0]   rx_rem;
  logic [N-1:0]      sof_n, eof_n, sop_n, eop_n, src_n, dst_n;
  logic [DW-1:0]     tx_data;
  logic [RW-1:0]     tx_rem;
  logic              tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_n, tx_dst_n;
  logic [CW-1:0]     tx_ch;

  logic [DW-1:0]     d_u [N];
  logic [RW-1:0]     r_u [N];
  logic              sof_u [N], eof_u [N], sop_u [N], eop_u [N], src_u [N], dst_u [N];

`ifdef FL_CUTTER_ARBITER_STATS_EN
  logic              cnt_clear;
  logic [N*32-1:0]   frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign rx_data[g*DW +: DW] = d_u[g];
    assign rx_rem[g*RW +: RW]  = r_u[g];
    assign sof_n[g] = sof_u[g];
    assign eof_n[g] = eof_u[g];
    assign sop_n[g] = sop_u[g];
    assign eop_n[g] = eop_u[g];
    assign src_n[g] = src_u[g];
    assign dst_u[g] = dst_n[g];
  end

  fl_cutter_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .DREM_WIDTH(RW), .CHAN_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(sof_n), .RX_EOF_N(eof_n), .RX_SOP_N(sop_n), .RX_EOP_N(eop_n),
    .RX_SRC_RDY_N(src_n), .RX_DST_RDY_N(dst_n),
    .TX_DATA(tx_data), .TX_REM(tx_rem),
    .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
    .TX_SRC_RDY_N(tx_src_n), .TX_DST_RDY_N(tx_dst_n), .TX_CHANNEL(tx_ch)
`ifdef FL_CUTTER_ARBITER_STATS_EN
    , .CNT_CLEAR(cnt_clear), .FRAME_CNT(frame_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int i, input int f, input int p);
    return {16'(i), 16'(f), 32'(p)};
  endfunction

  // 3 parts of 95 bytes = 12 words each; last word of a part holds 7 bytes.
  function automatic logic [6:0] fctl(input int p);
    logic [2:0] rem;
    rem = (p % 12 == 11) ? 3'd6 : 3'd7;
    return {rem, p != 0, p != 35, p % 12 != 0, p % 12 != 11};
  endfunction

  function automatic logic [6:0] tx_ctl();
    return {tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n};
  endfunction

  task automatic drv(input int i, input logic v, input logic [63:0] d, input logic [6:0] c);
    src_u[i] = !v;
    d_u[i]   = d;
    {r_u[i], sof_u[i], eof_u[i], sop_u[i], eop_u[i]} = c;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drv(i, 1'b0, 64'd0, 7'b000_1111);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_src"}, tx_src_n, 1);
    chk({tag, "_dst"}, dst_n, 4'b1111);
    chk({tag, "_ch"}, tx_ch, 0);
  endtask

  // n-word frame on input i with cutter always ready; bounded wait for the grant.
  task automatic send_frame(input int i, input int n, input int tag);
    int p;
    p = 0;
    for (int c = 0; c < 100 && p < n; c++) begin
      @(posedge CLK); #1;
      drv(i, 1'b1, wd(i, tag, p),
          {(p == n-1) ? 3'd0 : 3'd7, p != 0, p != n-1, p != 0, p != n-1});
      #1;
      if (!dst_u[i]) p++;
    end
    @(posedge CLK); #1;
    drv(i, 1'b0, 64'd0, IDLE_CTL);
    chk("send_done", p, n);
  endtask

  initial begin
    int pos [N];
    int frm [N];
    int ofrm [N];
    bit took [N];
    int exp_ch, opos, nfr, xfers;
    bit exp_idle, lk, done;

    // ---------------- reset and idle ----------------
    RESET = 1'b1;
    tx_dst_n = 1'b0;
`ifdef FL_CUTTER_ARBITER_STATS_EN
    cnt_clear = 1'b0;
`endif
    idle_all();
    repeat (2) @(posedge CLK);
    #2;
    chk_idle("rst");
    chk("rst_data", tx_data, 0);
    chk("rst_ctl", tx_ctl(), IDLE_CTL);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #2;
      chk_idle("idle");
    end

    // ---------------- fairness: 2 rounds of 36-word frames ----------------
    for (int i = 0; i < N; i++) begin pos[i] = 0; frm[i] = 0; ofrm[i] = 0; took[i] = 0; end
    exp_ch = 0; opos = 0; nfr = 0; exp_idle = 1;
    for (int c = 0; c < 400 && nfr < 8; c++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++)
        if (took[i]) begin
          pos[i]++;
          if (pos[i] == 36) begin pos[i] = 0; frm[i]++; end
        end
      for (int i = 0; i < N; i++) drv(i, frm[i] < 2, wd(i, frm[i], pos[i]), fctl(pos[i]));
      #1;
      for (int i = 0; i < N; i++) took[i] = !dst_u[i] && !src_u[i];
      if (exp_idle) begin
        chk("fair_bubble", tx_src_n, 1);
        chk("fair_bubble_dst", dst_n, 4'b1111);
        exp_idle = 0;
      end else begin
        chk("fair_ch", tx_ch, exp_ch);
        chk("fair_vld", tx_src_n, 0);
        chk("fair_data", tx_data, wd(exp_ch, ofrm[exp_ch], opos));
        chk("fair_ctl", tx_ctl(), fctl(opos));
        if (opos == 35) begin
          opos = 0; ofrm[exp_ch]++; exp_ch = (exp_ch + 1) % N; nfr++; exp_idle = 1;
        end else opos++;
      end
    end
    chk("fair_frames", nfr, 8);
    @(posedge CLK); #1;
    idle_all();

    // ---------------- isolation: input 2 waits behind input 1 ----------------
    @(posedge CLK); #1;
    drv(1, 1'b1, wd(1, 10, 0), 7'b111_0101);
    #1; chk("iso_idle", tx_src_n, 1);
    @(posedge CLK); #1;
    drv(2, 1'b1, wd(2, 10, 0), ONE_CTL);
    #1;
    chk("iso_ch1", tx_ch, 1);
    chk("iso_w0", tx_data, wd(1, 10, 0));
    chk("iso_dst_w0", dst_n, 4'b1101);
    @(posedge CLK); #1;
    drv(1, 1'b1, wd(1, 10, 1), MID_CTL);
    #1;
    chk("iso_w1", tx_data, wd(1, 10, 1));
    chk("iso_dst_w1", dst_n, 4'b1101);
    @(posedge CLK); #1;
    drv(1, 1'b1, wd(1, 10, 2), 7'b111_1010);
    #1;
    chk("iso_eof", tx_eof_n, 0);
    chk("iso_dst_w2", dst_n, 4'b1101);
    @(posedge CLK); #1;
    drv(1, 1'b0, 64'd0, IDLE_CTL);
    #1; chk("iso_gap_src", tx_src_n, 1);
    chk("iso_gap_dst", dst_n, 4'b1111);
    @(posedge CLK); #2;
    chk("iso_ch2", tx_ch, 2);
    chk("iso_single", tx_data, wd(2, 10, 0));
    chk("iso_single_ctl", tx_ctl(), ONE_CTL);
    chk("iso_dst2", dst_n, 4'b1011);
    @(posedge CLK); #1;
    drv(2, 1'b0, 64'd0, IDLE_CTL);
    #1; chk("iso_end", tx_src_n, 1);

    // ---------------- backpressure on input 0 ----------------
    // input 1 shows a non-SOF word: never a request, must stay stalled
    drv(1, 1'b1, wd(1, 99, 5), MID_CTL);
    pos[0] = 0; took[0] = 0; lk = 0; xfers = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge CLK); #1;
      if (took[0]) pos[0]++;
      if (pos[0] == 12) done = 1;
      else begin
        drv(0, 1'b1, wd(0, 20, pos[0]),
            {(pos[0] == 11) ? 3'd6 : 3'd7, pos[0] != 0, pos[0] != 11, pos[0] != 0, pos[0] != 11});
        tx_dst_n = ($urandom_range(0, 3) == 0);
        #1;
        if (!lk) begin
          chk("bp_grant_dst", dst_n, 4'b1111);
          lk = 1;
        end else begin
          chk("bp_dst", dst_n, {3'b111, tx_dst_n});
          chk("bp_data", tx_data, wd(0, 20, xfers));
          if (!tx_dst_n && !tx_src_n) xfers++;
        end
        took[0] = !dst_u[0] && !src_u[0];
      end
    end
    chk("bp_xfers", xfers, 12);
    tx_dst_n = 1'b0;
    idle_all();

    // ---------------- reset mid-frame on input 3 ----------------
    send_frame(2, 1, 30);
    @(posedge CLK); #1;
    drv(3, 1'b1, wd(3, 40, 0), 7'b111_0101);
    #1; chk("rmf_idle", tx_src_n, 1);
    @(posedge CLK); #2;
    chk("rmf_ch3", tx_ch, 3);
    for (int w = 1; w < 3; w++) begin
      @(posedge CLK); #1;
      drv(3, 1'b1, wd(3, 40, w), MID_CTL);
      #1; chk("rmf_word", tx_data, wd(3, 40, w));
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    drv(3, 1'b1, wd(3, 40, 3), MID_CTL);
    #1;
    chk_idle("rmf_rst");
    chk("rmf_rst_data", tx_data, 0);
    chk("rmf_rst_ctl", tx_ctl(), IDLE_CTL);
    @(posedge CLK); #1;
    RESET = 1'b0;
    drv(3, 1'b1, wd(3, 41, 0), ONE_CTL);
    drv(1, 1'b1, wd(1, 41, 0), ONE_CTL);
    #1; chk_idle("rmf_post");
    @(posedge CLK); #2;
    chk("rmf_first_ch", tx_ch, 1);
    chk("rmf_first_data", tx_data, wd(1, 41, 0));
    chk("rmf_first_dst", dst_n, 4'b1101);
    @(posedge CLK); #1;
    drv(1, 1'b0, 64'd0, IDLE_CTL);
    #1; chk("rmf_gap", tx_src_n, 1);
    @(posedge CLK); #2;
    chk("rmf_second_ch", tx_ch, 3);
    chk("rmf_second_data", tx_data, wd(3, 41, 0));
    @(posedge CLK); #1;
    drv(3, 1'b0, 64'd0, IDLE_CTL);
    #1; chk("rmf_end", tx_src_n, 1);

`ifdef FL_CUTTER_ARBITER_STATS_EN
    // ---------------- frame counters ----------------
    @(posedge CLK); #1;
    cnt_clear = 1'b1;
    @(posedge CLK); #1;
    cnt_clear = 1'b0;
    chk("cnt_cleared", frame_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      send_frame(0, (k % 2) + 1, 50 + k);
      if (k < 2) send_frame(1, 2, 60 + k);
    end
    @(posedge CLK); #2;
    chk("cnt0", frame_cnt[31:0], 5);
    chk("cnt1", frame_cnt[63:32], 2);
    chk("cnt23", frame_cnt[127:64], 0);
    @(posedge CLK); #1;
    drv(0, 1'b1, wd(0, 70, 0), ONE_CTL);
    @(posedge CLK); #1;
    cnt_clear = 1'b1;
    #1; chk("clr_eof_xfer", tx_eof_n | tx_src_n, 0);
    @(posedge CLK); #1;
    cnt_clear = 1'b0;
    drv(0, 1'b0, 64'd0, IDLE_CTL);
    #1; chk("clr_prio", frame_cnt[31:0], 0);
    chk("clr_all", frame_cnt[63:32], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
